udma_smi_cmd_seq: RTL

- Command sequencer directly upstream of the SMI (MDIO) controller.
- Buffers register-level MDIO read/write commands in a small FIFO and issues them one at a time to the controller through its start/busy/nd handshake.
- Captures read data into a response FIFO for the uDMA register/RX side.
- Bounds every transaction with a watchdog so a stuck controller cannot hang software.

---
 rtl/udma_smi_cmd_seq_if.sv | 45 ++++
 rtl/udma_smi_cmd_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/udma_smi_cmd_seq_if.sv
// Sequencer bus: host command/response/status side plus the SMI controller handshake.
// slave = sequencer view; master = environment view (host software path and SMI controller).
interface udma_smi_cmd_seq_if #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_rw;
  logic [4:0]                   cmd_phy;
  logic [4:0]                   cmd_reg;
  logic [15:0]                  cmd_wdata;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [15:0]                  rsp_data;
  logic                         rsp_err;
  logic                         flush;
  logic                         busy;
  logic [$clog2(CMD_DEPTH):0]   cmd_level;
  logic [$clog2(RSP_DEPTH):0]   rsp_level;
  logic                         timeout;
  logic                         timeout_clr;
  logic                         smi_start;
  logic                         smi_rw;
  logic [4:0]                   smi_phy_addr;
  logic [4:0]                   smi_reg_addr;
  logic [15:0]                  smi_wr_data;
  logic                         smi_busy;
  logic                         smi_nd;
  logic [15:0]                  smi_rd_data;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_phy, cmd_reg, cmd_wdata, rsp_ready, flush, timeout_clr,
    input  smi_busy, smi_nd, smi_rd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, cmd_level, rsp_level, timeout,
    output smi_start, smi_rw, smi_phy_addr, smi_reg_addr, smi_wr_data
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_phy, cmd_reg, cmd_wdata, rsp_ready, flush, timeout_clr,
    output smi_busy, smi_nd, smi_rd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, cmd_level, rsp_level, timeout,
    input  smi_start, smi_rw, smi_phy_addr, smi_reg_addr, smi_wr_data
  );
endinterface

// File: rtl/udma_smi_cmd_seq.sv
// MDIO command sequencer: queues commands, issues one at a time to the SMI controller, queues read data.
// Start pulse 2 cycles after push into an idle, empty queue; cmd_ready drops when queue full, reads stall when rsp queue full.
module udma_smi_cmd_seq #(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  udma_smi_cmd_seq_if.slave      bus
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  typedef struct packed {
    logic        rw;
    logic [4:0]  phy;
    logic [4:0]  regaddr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } rsp_t;

  state_t       state, state_nxt;
  cmd_t         cmd_mem [CMD_DEPTH];
  cmd_t         cmd_head, cur;
  logic [CAW:0] cmd_wp, cmd_rp, cmd_level;
  logic         cmd_full, cmd_empty, cmd_push, cmd_pop;
  rsp_t         rsp_mem [RSP_DEPTH];
  rsp_t         rsp_wdat, rsp_head;
  logic [RAW:0] rsp_wp, rsp_rp, rsp_level;
  logic         rsp_full, rsp_empty, rsp_req, rsp_push, rsp_pop;
  logic [15:0]  wdog;
  logic         wdog_hit, abort, drop, timeout;

  assign cmd_level = cmd_wp - cmd_rp;
  assign cmd_empty = (cmd_wp == cmd_rp);
  assign cmd_full  = (cmd_wp[CAW] != cmd_rp[CAW]) && (cmd_wp[CAW-1:0] == cmd_rp[CAW-1:0]);
  assign cmd_head  = cmd_mem[cmd_rp[CAW-1:0]];
  assign cmd_push  = bus.cmd_valid && !cmd_full && !bus.flush;

  assign rsp_level = rsp_wp - rsp_rp;
  assign rsp_empty = (rsp_wp == rsp_rp);
  assign rsp_full  = (rsp_wp[RAW] != rsp_rp[RAW]) && (rsp_wp[RAW-1:0] == rsp_rp[RAW-1:0]);
  assign rsp_head  = rsp_mem[rsp_rp[RAW-1:0]];
  assign rsp_pop   = !rsp_empty && bus.rsp_ready;
  // A flushed in-flight read still completes on the wire; only its push is dropped.
  assign rsp_push  = rsp_req && !drop && !bus.flush && (!rsp_full || rsp_pop);

  assign wdog_hit  = (wdog == WDOG_LAST);

  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem[cmd_wp[CAW-1:0]] <= {bus.cmd_rw, bus.cmd_phy, bus.cmd_reg, bus.cmd_wdata};
  end

  always_ff @(posedge clk_i) begin
    if (rsp_push) rsp_mem[rsp_wp[RAW-1:0]] <= rsp_wdat;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      rsp_wp <= '0;
      rsp_rp <= '0;
    end else if (bus.flush) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      rsp_wp <= '0;
      rsp_rp <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
      if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
      if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    rsp_req   = 1'b0;
    rsp_wdat  = '0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        // Reads only go out when their response is guaranteed a slot.
        if (!cmd_empty && (cmd_head.rw || !rsp_full) && !bus.flush) begin
          cmd_pop   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wdog_hit)          abort     = 1'b1;
        else if (bus.smi_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!cur.rw && bus.smi_nd) begin
          rsp_req   = 1'b1;
          rsp_wdat  = {1'b0, bus.smi_rd_data};
          state_nxt = IDLE;
        end else if (cur.rw && !bus.smi_busy) begin
          state_nxt = IDLE;
        end else if (wdog_hit) begin
          abort = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      if (!cur.rw) begin
        rsp_req  = 1'b1;
        rsp_wdat = {1'b1, 16'hFFFF};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      cur <= '0;
    else if (cmd_pop) cur <= cmd_head;
  end

  // Counts cycles since the start pulse; value is k-1 in the k-th cycle after start.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                        wdog <= '0;
    else if (state == ISSUE)                            wdog <= '0;
    else if (state == WAIT_BUSY || state == WAIT_DONE)  wdog <= wdog + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 drop <= 1'b0;
    else if (state_nxt == IDLE)  drop <= 1'b0;
    else if (bus.flush)          drop <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)              timeout <= 1'b0;
    else if (abort)           timeout <= 1'b1;
    else if (bus.timeout_clr) timeout <= 1'b0;
  end

  assign bus.cmd_ready    = !cmd_full;
  assign bus.cmd_level    = cmd_level;
  assign bus.rsp_valid    = !rsp_empty;
  assign bus.rsp_data     = rsp_head.data;
  assign bus.rsp_err      = rsp_head.err;
  assign bus.rsp_level    = rsp_level;
  assign bus.busy         = (state != IDLE) || !cmd_empty;
  assign bus.timeout      = timeout;
  assign bus.smi_start    = (state == ISSUE);
  assign bus.smi_rw       = cur.rw;
  assign bus.smi_phy_addr = cur.phy;
  assign bus.smi_reg_addr = cur.regaddr;
  assign bus.smi_wr_data  = cur.wdata;
endmodule
